// File: rtl/wave_pkg.sv
// Shared definitions for the sine-wave sample ROM.
// Holds the address/data widths, the sample type, the reset (DAC mid-scale) value and the
// constant one-period sine table: round(2048 + 2047*sin(2*pi*k/16)), k = 0..15.
package wave_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] sample_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam sample_t RESET_VALUE = 12'd2048;

    localparam sample_t SINE_TABLE [DEPTH] = '{
        12'd2048, 12'd2831, 12'd3495, 12'd3939,
        12'd4095, 12'd3939, 12'd3495, 12'd2831,
        12'd2048, 12'd1265, 12'd601,  12'd157,
        12'd1,    12'd157,  12'd601,  12'd1265
    };

endpackage

// File: rtl/wave_sample_rom.sv
// Synchronous sine-wave sample ROM.
// Returns the table entry for the applied address one clock later.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous reset, active-low; forces sample to mid-scale (2048)
//   address  - table index (all 16 values valid)
//   sample   - registered 12-bit unsigned offset-binary sample
module wave_sample_rom
    import wave_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] sample
);

    sample_t sample_q;

    // Output is only ever driven from the register: no combinational address-to-sample path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_q <= RESET_VALUE;
        end else begin
            sample_q <= SINE_TABLE[address];
        end
    end

    assign sample = sample_q;

endmodule

// File: tb/tb_wave_sample_rom.sv
// Self-checking bench for wave_sample_rom: expected samples are pushed to a scoreboard queue
// when an address is driven and popped when the registered output is due.
module tb_wave_sample_rom;

    logic        clk;
    logic        rst;
    logic [3:0]  address;
    logic [11:0] sample;

    int total = 0;
    int bad   = 0;

    logic [11:0] exp_q [$];
    logic [11:0] model [16];

    wave_sample_rom u_dut (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .sample  (sample)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one address (away from the edge), record its expected sample, advance past the edge.
    task automatic step(input logic [3:0] a);
        address = a;
        exp_q.push_back(model[a]);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        address = 'x;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (sample !== 12'd2048) begin
            bad++;
            $display("FAIL reset_async got=%0d want=2048", sample);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (sample !== 12'd2048) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%0d want=2048", i, sample);
            end
        end
    endtask

    task automatic test_basic_read();
        logic [11:0] want;
        @(negedge clk);
        rst     = 1'b1;
        address = 4'd3;
        #1;
        total++;
        if (sample !== 12'd2048) begin
            bad++;
            $display("FAIL read_not_before got=%0d want=2048", sample);
        end
        step(4'd3);
        want = exp_q.pop_front();
        total++;
        if (sample !== want) begin
            bad++;
            $display("FAIL basic_read got=%0d want=%0d", sample, want);
        end
    endtask

    task automatic test_addr_change();
        logic [11:0] want;
        address = 4'd6;
        #2;
        total++;
        if (sample !== 12'd3939) begin
            bad++;
            $display("FAIL change_current got=%0d want=3939", sample);
        end
        step(4'd6);
        want = exp_q.pop_front();
        total++;
        if (sample !== want) begin
            bad++;
            $display("FAIL change_next got=%0d want=%0d", sample, want);
        end
    endtask

    task automatic test_sweep();
        logic [11:0] want;
        for (int a = 0; a < 16; a++) begin
            step(4'(a));
            want = exp_q.pop_front();
            total++;
            if (sample !== want) begin
                bad++;
                $display("FAIL sweep addr=%0d got=%0d want=%0d", a, sample, want);
            end
        end
        step(4'd0);
        want = exp_q.pop_front();
        total++;
        if (sample !== want) begin
            bad++;
            $display("FAIL wrap_15_0 got=%0d want=%0d", sample, want);
        end
    endtask

    task automatic test_mid_reset();
        logic [11:0] want;
        for (int a = 0; a <= 4; a++) begin
            step(4'(a));
            want = exp_q.pop_front();
            total++;
            if (sample !== want) begin
                bad++;
                $display("FAIL midrst_pre addr=%0d got=%0d want=%0d", a, sample, want);
            end
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (sample !== 12'd2048) begin
            bad++;
            $display("FAIL midrst_async got=%0d want=2048", sample);
        end
        address = 4'd12;
        @(posedge clk);
        #1;
        total++;
        if (sample !== 12'd2048) begin
            bad++;
            $display("FAIL midrst_hold got=%0d want=2048", sample);
        end
        @(negedge clk);
        rst = 1'b1;
        step(4'd12);
        want = exp_q.pop_front();
        total++;
        if (sample !== want) begin
            bad++;
            $display("FAIL midrst_release got=%0d want=%0d", sample, want);
        end
    endtask

    task automatic test_hold();
        logic [11:0] want;
        for (int i = 0; i < 8; i++) begin
            step(4'd10);
            want = exp_q.pop_front();
            total++;
            if (sample !== want) begin
                bad++;
                $display("FAIL hold_edge cyc=%0d got=%0d want=%0d", i, sample, want);
            end
            #3;
            total++;
            if (sample !== want) begin
                bad++;
                $display("FAIL hold_mid cyc=%0d got=%0d want=%0d", i, sample, want);
            end
        end
    endtask

    initial begin
        model = '{12'd2048, 12'd2831, 12'd3495, 12'd3939, 12'd4095, 12'd3939, 12'd3495, 12'd2831,
                  12'd2048, 12'd1265, 12'd601,  12'd157,  12'd1,    12'd157,  12'd601,  12'd1265};
        test_reset();
        test_basic_read();
        test_addr_change();
        test_sweep();
        test_mid_reset();
        test_hold();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
